// File: rtl/instr_fetch.sv
// instr_fetch: single-stage instruction fetch with a registered output slot.
// The PC register drives the ROM address. The ROM word is captured into the
// output register together with its address.
// An optional BREAK/HALT feature is enabled by defining FETCH_BRK_HALT_EN.
// In the default build, BREAK words pass through as ordinary instructions.
//
// Output handshake (if_valid / if_ready):
// - An instruction transfers on every rising edge where if_valid && if_ready.
// - While if_valid is high and if_ready is low, if_instr and if_pc are held.
// - if_valid never depends combinationally on if_ready.
//
// FSM state is observable on the halted output (RUN=0, HALT=1).
module instr_fetch #(
  parameter int ADDR_W   = 5,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_instr,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [31:0]       if_instr,
  output logic [ADDR_W-1:0] if_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              brk_hit,
  output logic [19:0]       brk_code,
  input  logic              resume,
  output logic              halted
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              valid_q, valid_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] ifpc_q, ifpc_d;
  logic              brk_hit_q, brk_hit_d;
  logic [19:0]       brk_code_q, brk_code_d;

  logic accept;
  logic can_load;
  logic is_brk;
  logic resume_en;

  assign accept   = valid_q && if_ready;
  assign can_load = !valid_q || accept;

`ifdef FETCH_BRK_HALT_EN
  // BREAK: opcode field zero and funct field 0x0D.
  assign is_brk    = (rom_instr[31:26] == 6'd0) && (rom_instr[5:0] == 6'h0D);
  assign resume_en = resume;
`else
  // Without the feature, BREAK is not special and resume has no effect.
  logic unused_resume;
  assign unused_resume = resume;
  assign is_brk        = 1'b0;
  assign resume_en     = 1'b0;
`endif

  // Next-state logic: redirect overrides everything; RUN loads when the slot frees up.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    instr_d    = instr_q;
    ifpc_d     = ifpc_q;
    brk_hit_d  = 1'b0;
    brk_code_d = brk_code_q;

    if (accept) begin
      valid_d = 1'b0;
    end

    if (redirect_valid) begin
      // Any same-cycle handshake has already completed above; drop the slot.
      pc_d    = redirect_pc;
      valid_d = 1'b0;
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (can_load) begin
            instr_d = rom_instr;
            ifpc_d  = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + ADDR_W'(1);
            if (is_brk) begin
              brk_hit_d  = 1'b1;
              brk_code_d = rom_instr[25:6];
              state_d    = ST_HALT;
            end
          end
        end
        ST_HALT: begin
          // No loads here; a held BREAK drains through the accept path above.
          if (resume_en) begin
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      pc_q       <= ADDR_W'(RESET_PC);
      valid_q    <= 1'b0;
      instr_q    <= 32'd0;
      ifpc_q     <= '0;
      brk_hit_q  <= 1'b0;
      brk_code_q <= 20'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      ifpc_q     <= ifpc_d;
      brk_hit_q  <= brk_hit_d;
      brk_code_q <= brk_code_d;
    end
  end

  assign rom_addr = pc_q;
  assign if_valid = valid_q;
  assign if_instr = instr_q;
  assign if_pc    = ifpc_q;
  assign brk_hit  = brk_hit_q;
  assign brk_code = brk_code_q;
  assign halted   = (state_q == ST_HALT);

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed table plus hand sequences for instr_fetch.
// The same file builds with or without FETCH_BRK_HALT_EN.
module tb_instr_fetch;

`ifdef FETCH_BRK_HALT_EN
  localparam bit BRK_EN = 1'b1;
`else
  localparam bit BRK_EN = 1'b0;
`endif

  localparam logic [19:0] C3 = BRK_EN ? 20'h00003 : 20'h00000;
  localparam logic [19:0] C5 = BRK_EN ? 20'h00005 : 20'h00000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [4:0]  rom_addr;
  logic [31:0] rom_instr;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [4:0]  if_pc;
  logic        redirect_valid;
  logic [4:0]  redirect_pc;
  logic        brk_hit;
  logic [19:0] brk_code;
  logic        resume;
  logic        halted;

  logic [31:0] rom [32];
  assign rom_instr = rom[rom_addr];

  instr_fetch #(.ADDR_W(5), .RESET_PC(0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rom_addr       (rom_addr),
    .rom_instr      (rom_instr),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .brk_hit        (brk_hit),
    .brk_code       (brk_code),
    .resume         (resume),
    .halted         (halted)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Compare every output; instr/pc only matter when the slot is valid.
  task automatic check_all(input string name, input logic ev, input logic [31:0] ei,
                           input logic [4:0] ep, input logic [4:0] ea, input logic eh,
                           input logic ehalt, input logic [19:0] ecode);
    chk({name, ".valid"}, 32'(if_valid), 32'(ev));
    if (ev) begin
      chk({name, ".instr"}, if_instr, ei);
      chk({name, ".pc"}, 32'(if_pc), 32'(ep));
    end
    chk({name, ".rom_addr"}, 32'(rom_addr), 32'(ea));
    chk({name, ".brk_hit"}, 32'(brk_hit), 32'(eh));
    chk({name, ".halted"}, 32'(halted), 32'(ehalt));
    chk({name, ".brk_code"}, 32'(brk_code), 32'(ecode));
  endtask

  // ---------------- driver ----------------
  // Drive inputs, take one rising edge, then compare just after it.
  task automatic step(input string name, input logic rdy, input logic rv, input logic [4:0] rpc,
                      input logic res, input logic ev, input logic [31:0] ei, input logic [4:0] ep,
                      input logic [4:0] ea, input logic eh, input logic ehalt,
                      input logic [19:0] ecode);
    if_ready       = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    resume         = res;
    @(posedge clk);
    #1;
    check_all(name, ev, ei, ep, ea, eh, ehalt, ecode);
  endtask

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [4:0]  rpc;
    logic        res;
    logic        ev;
    logic [31:0] ei;
    logic [4:0]  ep;
    logic [4:0]  ea;
  } vec_t;

  vec_t vecs[11];

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 32'h24000000 | (32'(i) << 16) | 32'(i);
    rom[0]  = 32'h24010001;
    rom[1]  = 32'h24020002;
    rom[2]  = 32'h24030003;
    rom[3]  = 32'h000000CD;
    rom[4]  = 32'h24040004;
    rom[5]  = 32'h24050005;
    rom[6]  = 32'h0000014D;
    rom[7]  = 32'h24060006;
    rom[10] = 32'h24080008;
    rom[31] = 32'h241F001F;

    // Fields: ready, redirect_valid, redirect_pc, resume | if_valid, if_instr, if_pc, rom_addr.
    vecs[0]  = '{1'b1, 1'b0, 5'h00, 1'b0, 1'b1, 32'h24010001, 5'h00, 5'h01};
    vecs[1]  = '{1'b1, 1'b0, 5'h00, 1'b0, 1'b1, 32'h24020002, 5'h01, 5'h02};
    vecs[2]  = '{1'b0, 1'b0, 5'h00, 1'b0, 1'b1, 32'h24020002, 5'h01, 5'h02};
    vecs[3]  = '{1'b0, 1'b0, 5'h00, 1'b0, 1'b1, 32'h24020002, 5'h01, 5'h02};
    vecs[4]  = '{1'b0, 1'b0, 5'h00, 1'b0, 1'b1, 32'h24020002, 5'h01, 5'h02};
    vecs[5]  = '{1'b1, 1'b0, 5'h00, 1'b0, 1'b1, 32'h24030003, 5'h02, 5'h03};
    vecs[6]  = '{1'b0, 1'b0, 5'h00, 1'b0, 1'b1, 32'h24030003, 5'h02, 5'h03};
    vecs[7]  = '{1'b0, 1'b1, 5'h0A, 1'b0, 1'b0, 32'h00000000, 5'h00, 5'h0A};
    vecs[8]  = '{1'b1, 1'b0, 5'h00, 1'b0, 1'b1, 32'h24080008, 5'h0A, 5'h0B};
    vecs[9]  = '{1'b1, 1'b1, 5'h02, 1'b0, 1'b0, 32'h00000000, 5'h00, 5'h02};
    vecs[10] = '{1'b1, 1'b0, 5'h00, 1'b0, 1'b1, 32'h24030003, 5'h02, 5'h03};

    if_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 5'h00;
    resume         = 1'b0;

    // Reset state, sampled while rst_n is still low.
    #12;
    check_all("reset", 1'b0, 32'h0, 5'h0, 5'h00, 1'b0, 1'b0, 20'h0);
    chk("reset.instr", if_instr, 32'h0);
    chk("reset.pc", 32'(if_pc), 32'h0);
    rst_n = 1'b1;

    // Straight-line fetch, 3-cycle stall, redirect in a stall, redirect with handshake.
    for (int i = 0; i < 11; i++) begin
      step($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].rv, vecs[i].rpc, vecs[i].res,
           vecs[i].ev, vecs[i].ei, vecs[i].ep, vecs[i].ea, 1'b0, 1'b0, 20'h0);
    end

    // BREAK at address 3.
`ifdef FETCH_BRK_HALT_EN
    step("brk3_load",   1'b1, 1'b0, 5'h00, 1'b0, 1'b1, 32'h000000CD, 5'h03, 5'h04, 1'b1, 1'b1, 20'h3);
    step("brk3_acc",    1'b1, 1'b0, 5'h00, 1'b0, 1'b0, 32'h0,        5'h00, 5'h04, 1'b0, 1'b1, 20'h3);
    step("halt_idle",   1'b1, 1'b0, 5'h00, 1'b0, 1'b0, 32'h0,        5'h00, 5'h04, 1'b0, 1'b1, 20'h3);
    step("resume",      1'b1, 1'b0, 5'h00, 1'b1, 1'b0, 32'h0,        5'h00, 5'h04, 1'b0, 1'b0, 20'h3);
    step("post_resume", 1'b1, 1'b0, 5'h00, 1'b0, 1'b1, 32'h24040004, 5'h04, 5'h05, 1'b0, 1'b0, 20'h3);
`else
    step("brk3_pass",   1'b1, 1'b0, 5'h00, 1'b0, 1'b1, 32'h000000CD, 5'h03, 5'h04, 1'b0, 1'b0, 20'h0);
    step("after_brk3",  1'b1, 1'b0, 5'h00, 1'b0, 1'b1, 32'h24040004, 5'h04, 5'h05, 1'b0, 1'b0, 20'h0);
`endif
    step("addr5",         1'b1, 1'b0, 5'h00, 1'b0, 1'b1, 32'h24050005, 5'h05, 5'h06, 1'b0, 1'b0, C3);

    // BREAK at address 6, then redirect to the top of the address space.
`ifdef FETCH_BRK_HALT_EN
    step("brk6_load",    1'b1, 1'b0, 5'h00, 1'b0, 1'b1, 32'h0000014D, 5'h06, 5'h07, 1'b1, 1'b1, 20'h5);
    step("brk6_hold",    1'b0, 1'b0, 5'h00, 1'b0, 1'b1, 32'h0000014D, 5'h06, 5'h07, 1'b0, 1'b1, 20'h5);
    step("resume_redir", 1'b0, 1'b1, 5'h1F, 1'b1, 1'b0, 32'h0,        5'h00, 5'h1F, 1'b0, 1'b0, 20'h5);
`else
    step("brk6_pass",    1'b1, 1'b0, 5'h00, 1'b0, 1'b1, 32'h0000014D, 5'h06, 5'h07, 1'b0, 1'b0, 20'h0);
    step("follow_brk6",  1'b1, 1'b0, 5'h00, 1'b0, 1'b1, 32'h24060006, 5'h07, 5'h08, 1'b0, 1'b0, 20'h0);
    step("redir_1f",     1'b1, 1'b1, 5'h1F, 1'b0, 1'b0, 32'h0,        5'h00, 5'h1F, 1'b0, 1'b0, 20'h0);
`endif

    // PC wrap, resume ignored in RUN, then re-enter HALT (or stall) before a reset.
    step("wrap",          1'b1, 1'b0, 5'h00, 1'b0, 1'b1, 32'h241F001F, 5'h1F, 5'h00, 1'b0, 1'b0, C5);
    step("resume_in_run", 1'b0, 1'b0, 5'h00, 1'b1, 1'b1, 32'h241F001F, 5'h1F, 5'h00, 1'b0, 1'b0, C5);
    step("redir3",        1'b1, 1'b1, 5'h03, 1'b0, 1'b0, 32'h0,        5'h00, 5'h03, 1'b0, 1'b0, C5);
    step("brk3_again",    1'b0, 1'b0, 5'h00, 1'b0, 1'b1, 32'h000000CD, 5'h03, 5'h04, BRK_EN, BRK_EN, C3);
    step("stall_held",    1'b0, 1'b0, 5'h00, 1'b0, 1'b1, 32'h000000CD, 5'h03, 5'h04, 1'b0,   BRK_EN, C3);

    // Asynchronous reset between clock edges.
    #3;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 1'b0, 32'h0, 5'h0, 5'h00, 1'b0, 1'b0, 20'h0);
    chk("async_rst.instr", if_instr, 32'h0);
    chk("async_rst.pc", 32'(if_pc), 32'h0);
    #2;
    rst_n = 1'b1;
    step("after_reset", 1'b1, 1'b0, 5'h00, 1'b0, 1'b1, 32'h24010001, 5'h00, 5'h01, 1'b0, 1'b0, 20'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
